// File: rtl/fifo_wr_gen.sv
// FIFO write-side traffic generator: bursts of writes separated by idle gaps,
// with incrementing or Galois-LFSR data, stall accounting and a done pulse.
module fifo_wr_gen #(
    parameter int unsigned           DSIZE = 8,
    parameter int unsigned           CNTW  = 16,
    parameter logic [DSIZE-1:0]      POLY  = 8'hB8
) (
    input  logic             wclk,
    input  logic             wrst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [7:0]       burst_len,
    input  logic [7:0]       gap_len,
    input  logic [CNTW-1:0]  total_len,
    input  logic             pattern_sel,
    input  logic [DSIZE-1:0] seed,
    input  logic             wfull,
    output logic             winc,
    output logic [DSIZE-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [CNTW-1:0]  wr_cnt,
    output logic [CNTW-1:0]  stall_cnt
);

    typedef enum logic [1:0] {IDLE, BURST, GAP, DONE} state_t;

    state_t           state, state_nxt;
    logic [7:0]       burst_q, gap_q, burst_cnt, gap_cnt;
    logic [CNTW-1:0]  total_q;
    logic             pat_q;

    logic [7:0]       eff_burst;
    logic             last_wr, burst_end, gap_end;
    logic [DSIZE-1:0] wdata_adv;

    assign winc      = (state == BURST) && !wfull;
    assign busy      = (state == BURST) || (state == GAP);
    assign done      = (state == DONE);

    assign eff_burst = (burst_q == 8'd0) ? 8'd1 : burst_q;
    assign last_wr   = (wr_cnt + CNTW'(1)) == total_q;
    assign burst_end = (burst_cnt + 8'd1) == eff_burst;
    assign gap_end   = gap_cnt == (gap_q - 8'd1);
    assign wdata_adv = pat_q ? ((wdata >> 1) ^ (wdata[0] ? POLY : '0))
                             : wdata + DSIZE'(1);

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) state <= IDLE;
        else         state <= state_nxt;
    end

    // Abort wins over both the done transition and the burst/gap sequencing.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = (total_len == '0) ? DONE : BURST;
            BURST: begin
                if (abort)
                    state_nxt = IDLE;
                else if (winc) begin
                    if (last_wr)        state_nxt = DONE;
                    else if (burst_end) state_nxt = (gap_q != 8'd0) ? GAP : BURST;
                end
            end
            GAP: begin
                if (abort)        state_nxt = IDLE;
                else if (gap_end) state_nxt = BURST;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A write accepted in the abort cycle is still counted and advances the data.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            burst_q   <= '0;
            gap_q     <= '0;
            total_q   <= '0;
            pat_q     <= 1'b0;
            burst_cnt <= '0;
            gap_cnt   <= '0;
            wdata     <= '0;
            wr_cnt    <= '0;
            stall_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        burst_q   <= burst_len;
                        gap_q     <= gap_len;
                        total_q   <= total_len;
                        pat_q     <= pattern_sel;
                        burst_cnt <= '0;
                        gap_cnt   <= '0;
                        wr_cnt    <= '0;
                        stall_cnt <= '0;
                        wdata     <= (pattern_sel && seed == '0) ? DSIZE'(1) : seed;
                    end
                end
                BURST: begin
                    gap_cnt <= '0;
                    if (winc) begin
                        wr_cnt    <= wr_cnt + CNTW'(1);
                        wdata     <= wdata_adv;
                        burst_cnt <= burst_end ? 8'd0 : burst_cnt + 8'd1;
                    end else if (stall_cnt != '1) begin
                        stall_cnt <= stall_cnt + CNTW'(1);
                    end
                end
                GAP:     gap_cnt <= gap_cnt + 8'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_gen.sv
// Self-checking bench for fifo_wr_gen: directed cases plus random traffic
// checked against an event-queue model of the expected write schedule.
module tb_fifo_wr_gen;

    logic        wclk = 1'b0;
    logic        wrst_n;
    logic        start, abort, pattern_sel, wfull;
    logic [7:0]  burst_len, gap_len, seed;
    logic [15:0] total_len;
    logic        winc, busy, done;
    logic [7:0]  wdata;
    logic [15:0] wr_cnt, stall_cnt;

    int checks = 0;
    int errors = 0;

    // Expected schedule: data word (>=0), idle gap slot (-1), done pulse (-2).
    int q[$];
    int m_cnt   = 0;
    int m_stall = 0;
    logic [7:0] cap[$];

    fifo_wr_gen #(.DSIZE(8), .CNTW(16), .POLY(8'hB8)) dut (
        .wclk(wclk), .wrst_n(wrst_n), .start(start), .abort(abort),
        .burst_len(burst_len), .gap_len(gap_len), .total_len(total_len),
        .pattern_sel(pattern_sel), .seed(seed), .wfull(wfull),
        .winc(winc), .wdata(wdata), .busy(busy), .done(done),
        .wr_cnt(wr_cnt), .stall_cnt(stall_cnt)
    );

    always #5 wclk = ~wclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return v[0] ? ((v >> 1) ^ 8'hB8) : (v >> 1);
    endfunction

    task automatic build_schedule();
        int eb;
        logic [7:0] d;
        eb = (burst_len == 0) ? 1 : int'(burst_len);
        d  = (pattern_sel && seed == 8'h00) ? 8'h01 : seed;
        q.delete();
        for (int i = 0; i < int'(total_len); i++) begin
            q.push_back(int'(d));
            d = pattern_sel ? lfsr_step(d) : d + 8'h01;
            if ((i + 1) % eb == 0 && i + 1 < int'(total_len))
                for (int g = 0; g < int'(gap_len); g++) q.push_back(-1);
        end
        q.push_back(-2);
        m_cnt   = 0;
        m_stall = 0;
    endtask

    // Called at posedge+1; checks just before the next edge, updates the model, advances.
    task automatic step();
        logic ew, eb, ed;
        #8;
        ew = 1'b0; eb = 1'b0; ed = 1'b0;
        if (q.size() != 0) begin
            if (q[0] >= 0)       begin ew = !wfull; eb = 1'b1; end
            else if (q[0] == -1) eb = 1'b1;
            else                 ed = 1'b1;
        end
        chk("winc", winc, ew);
        chk("busy", busy, eb);
        chk("done", done, ed);
        chk("wr_cnt", wr_cnt, m_cnt);
        chk("stall_cnt", stall_cnt, m_stall);
        if (ew) chk("wdata", wdata, q[0]);
        if (winc === 1'b1) cap.push_back(wdata);

        if (q.size() == 0) begin
            if (start) build_schedule();
        end else if (q[0] >= 0) begin
            if (wfull) m_stall++;
            else begin m_cnt++; void'(q.pop_front()); end
            if (abort) q.delete();
        end else if (q[0] == -1) begin
            if (abort) q.delete();
            else void'(q.pop_front());
        end else begin
            void'(q.pop_front());
        end
        @(posedge wclk);
        #1;
    endtask

    task automatic set_cfg(input logic [7:0] bl, input logic [7:0] gl, input logic [15:0] tl,
                           input logic ps, input logic [7:0] sd);
        burst_len = bl; gap_len = gl; total_len = tl; pattern_sel = ps; seed = sd;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        wrst_n = 1'b0; start = 1'b0; abort = 1'b0; wfull = 1'b0;
        set_cfg(8'd0, 8'd0, 16'd0, 1'b0, 8'h00);
        #1;
        chk("rst_winc", winc, 1'b0);
        chk("rst_wdata", wdata, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_wr_cnt", wr_cnt, 16'd0);
        chk("rst_stall_cnt", stall_cnt, 16'd0);
        @(posedge wclk);
        #1;
        wrst_n = 1'b1;

        // Case 1: 4-write bursts, 2-cycle gap, incrementing from 10.
        set_cfg(8'd4, 8'd2, 16'd8, 1'b0, 8'h10);
        cap.delete();
        pulse_start();
        repeat (16) step();
        chk("c1_count", cap.size(), 8);
        for (int i = 0; i < 8 && i < cap.size(); i++) chk("c1_data", cap[i], 8'h10 + i);

        // Case 2: same, with three stalled cycles inside the first burst.
        cap.delete();
        pulse_start();
        step();
        wfull = 1'b1;
        repeat (3) step();
        wfull = 1'b0;
        repeat (16) step();
        chk("c2_stall", stall_cnt, 16'd3);
        chk("c2_count", cap.size(), 8);
        for (int i = 0; i < 8 && i < cap.size(); i++) chk("c2_data", cap[i], 8'h10 + i);

        // Case 3: LFSR from zero seed, burst_len 0 acts as 1.
        set_cfg(8'd0, 8'd0, 16'd3, 1'b1, 8'h00);
        cap.delete();
        pulse_start();
        repeat (6) step();
        chk("c3_count", cap.size(), 3);
        if (cap.size() == 3) begin
            chk("c3_d0", cap[0], 8'h01);
            chk("c3_d1", cap[1], 8'hB8);
            chk("c3_d2", cap[2], 8'h5C);
        end

        // Case 4: zero-length transfer goes straight to the done pulse.
        set_cfg(8'd4, 8'd1, 16'd0, 1'b0, 8'h33);
        pulse_start();
        repeat (3) step();

        // Case 5: start while busy is ignored; abort after five writes.
        set_cfg(8'd4, 8'd1, 16'd20, 1'b0, 8'h40);
        pulse_start();
        repeat (2) step();
        pulse_start();
        for (int n = 0; n < 40 && m_cnt < 5; n++) step();
        chk("c5_reach5", m_cnt, 5);
        abort = 1'b1;
        step();
        abort = 1'b0;
        repeat (4) step();
        set_cfg(8'd2, 8'd0, 16'd3, 1'b0, 8'h00);
        pulse_start();
        repeat (6) step();

        // Case 6: asynchronous reset in the middle of a burst.
        set_cfg(8'd8, 8'd0, 16'd30, 1'b0, 8'h21);
        pulse_start();
        repeat (3) step();
        #3;
        wrst_n = 1'b0;
        #1;
        chk("arst_winc", winc, 1'b0);
        chk("arst_wdata", wdata, 8'h00);
        chk("arst_busy", busy, 1'b0);
        chk("arst_done", done, 1'b0);
        chk("arst_wr_cnt", wr_cnt, 16'd0);
        chk("arst_stall_cnt", stall_cnt, 16'd0);
        q.delete();
        m_cnt = 0;
        m_stall = 0;
        @(posedge wclk);
        #1;
        wrst_n = 1'b1;
        repeat (3) step();
        set_cfg(8'd3, 8'd1, 16'd5, 1'b1, 8'h5A);
        pulse_start();
        repeat (10) step();

        // Random traffic.
        for (int n = 0; n < 2500; n++) begin
            set_cfg(8'($urandom_range(0, 5)), 8'($urandom_range(0, 3)),
                    16'($urandom_range(0, 20)), 1'($urandom), 8'($urandom));
            start = (q.size() == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
            abort = (q.size() != 0) && ($urandom_range(0, 49) == 0);
            wfull = ($urandom_range(0, 3) == 0);
            step();
        end
        start = 1'b0; abort = 1'b0; wfull = 1'b0;
        repeat (200) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
